// File: rtl/operand_packer_if.sv
// Operand packer bus: operand stream in, packed adder-tree group out.
interface operand_packer_if #(
    parameter int TREE_SIZE = 8,
    parameter int CNT_WIDTH = 16
);
    logic [31:0]             in_data;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic [32*TREE_SIZE-1:0] out;
    logic                    out_valid;
    logic                    sum_valid;
    logic [CNT_WIDTH-1:0]    group_count;

    modport master (
        output in_data, in_valid, in_last,
        input  in_ready, out, out_valid, sum_valid, group_count
    );

    modport slave (
        input  in_data, in_valid, in_last,
        output in_ready, out, out_valid, sum_valid, group_count
    );
endinterface

// File: rtl/operand_packer.sv
// Serial-to-parallel packer feeding the pipelined 32-bit adder tree.
// First word of a group lands in the MSB slot; short groups are zero padded.
module operand_packer #(
    parameter int TREE_SIZE    = 8,
    parameter int TREE_LATENCY = 3,
    parameter int CNT_WIDTH    = 16
) (
    input logic           clock,
    input logic           reset,
    operand_packer_if.slave bus
);
    localparam int CW = $clog2(TREE_SIZE);
    localparam int W  = 32 * TREE_SIZE;

    typedef enum logic {FILL, FLUSH} state_t;

    state_t                state, state_d;
    logic [CW-1:0]         cnt, cnt_d, slot;
    logic [W-1:0]          asm_q, asm_d;
    logic [W-1:0]          out_q, out_d;
    logic                  ov_q, ov_d;
    logic [CNT_WIDTH-1:0]  gc_q, gc_d;
    logic [TREE_LATENCY-1:0] sv_q;
    logic                  started;
    logic                  accept;
    logic                  full;

    assign bus.in_ready    = started && (state == FILL);
    assign bus.out         = out_q;
    assign bus.out_valid   = ov_q;
    assign bus.sum_valid   = sv_q[TREE_LATENCY-1];
    assign bus.group_count = gc_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign slot   = CW'(TREE_SIZE - 1) - cnt;
    assign full   = (cnt == CW'(TREE_SIZE - 1));

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        asm_d   = asm_q;
        out_d   = out_q;
        ov_d    = 1'b0;
        gc_d    = gc_q;
        unique case (state)
            FILL: begin
                if (accept) begin
                    asm_d[32*slot +: 32] = bus.in_data;
                    cnt_d = cnt + 1'b1;
                    // A full group bypasses FLUSH so back-to-back groups see no bubble
                    if (full) begin
                        out_d = asm_d;
                        ov_d  = 1'b1;
                        gc_d  = gc_q + 1'b1;
                        cnt_d = '0;
                        asm_d = '0;
                    end else if (bus.in_last) begin
                        state_d = FLUSH;
                    end
                end
            end
            FLUSH: begin
                out_d   = asm_q;
                ov_d    = 1'b1;
                gc_d    = gc_q + 1'b1;
                cnt_d   = '0;
                asm_d   = '0;
                state_d = FILL;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FILL;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            asm_q   <= '0;
            out_q   <= '0;
            ov_q    <= 1'b0;
            gc_q    <= '0;
            sv_q    <= '0;
            started <= 1'b0;
        end else begin
            cnt     <= cnt_d;
            asm_q   <= asm_d;
            out_q   <= out_d;
            ov_q    <= ov_d;
            gc_q    <= gc_d;
            sv_q    <= (sv_q << 1) | TREE_LATENCY'(ov_q);
            started <= 1'b1;
        end
    end
endmodule

// File: tb/tb_operand_packer.sv
// Randomized and directed bench for operand_packer against a
// transaction-level model (word queue, emit-time list).
module tb_operand_packer;
    localparam int TS   = 8;
    localparam int LAT  = 3;
    localparam int CNTW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    operand_packer_if #(.TREE_SIZE(TS), .CNT_WIDTH(CNTW)) bus ();

    operand_packer #(
        .TREE_SIZE(TS),
        .TREE_LATENCY(LAT),
        .CNT_WIDTH(CNTW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0]     q[$];
    int              emits[$];
    logic [32*TS-1:0] m_out;
    bit              m_ov;
    bit              m_flush;
    bit              m_started;
    int              m_gc;
    int              cyc;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic logic [32*TS-1:0] pack_group();
        logic [32*TS-1:0] r;
        r = '0;
        for (int k = 0; k < q.size(); k++)
            r[32*(TS-1-k) +: 32] = q[k];
        return r;
    endfunction

    function automatic bit exp_sum_valid();
        bit hit;
        hit = 1'b0;
        foreach (emits[i])
            if (emits[i] + LAT == cyc) hit = 1'b1;
        return hit;
    endfunction

    task automatic emit();
        m_out = pack_group();
        m_ov  = 1'b1;
        m_gc  = m_gc + 1;
        q.delete();
        emits.push_back(cyc + 1);
    endtask

    task automatic check_outputs();
        check("in_ready", 256'(bus.in_ready), 256'(m_started && !m_flush));
        check("out", 256'(bus.out), 256'(m_out));
        check("out_valid", 256'(bus.out_valid), 256'(m_ov));
        check("sum_valid", 256'(bus.sum_valid), 256'(exp_sum_valid()));
        check("group_count", 256'(bus.group_count), 256'(m_gc % (1 << CNTW)));
    endtask

    // Called at a falling edge: check state, drive inputs, predict next edge
    task automatic step(input bit v, input bit l, input logic [31:0] d);
        bit ready;
        check_outputs();
        bus.in_valid = v;
        bus.in_last  = l;
        bus.in_data  = d;
        ready = m_started && !m_flush;
        m_ov  = 1'b0;
        if (m_flush) begin
            emit();
            m_flush = 1'b0;
        end else if (v && ready) begin
            q.push_back(d);
            if (q.size() == TS) emit();
            else if (l) m_flush = 1'b1;
        end
        m_started = 1'b1;
        @(negedge clock);
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        q.delete();
        emits.delete();
        m_out     = '0;
        m_ov      = 1'b0;
        m_flush   = 1'b0;
        m_started = 1'b0;
        m_gc      = 0;
        check_outputs();
        @(negedge clock);
        cyc++;
        check_outputs();
        reset = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        logic [31:0] g1 [8];
        logic [31:0] g2 [8];
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        cyc = 0;
        @(negedge clock);
        do_reset();

        idle(1);
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 32'(i));
        idle(5);

        g1 = '{9, 8, 7, 0, 16, 6, 7, 8};
        g2 = '{0, 2, 5, 4, 7, 6, 7, 2};
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, g1[i]);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, g2[i]);
        idle(5);

        step(1'b1, 1'b0, 32'd5);
        step(1'b1, 1'b0, 32'd6);
        step(1'b1, 1'b1, 32'd7);
        step(1'b1, 1'b0, 32'd99);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'(i + 100));
        idle(5);

        step(1'b1, 1'b1, 32'd42);
        idle(5);
        for (int i = 1; i <= 8; i++) step(1'b1, i == 8, 32'(i + 20));
        idle(5);

        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 1'b0, 32'(i));
            idle(i % 3);
        end
        idle(5);

        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 32'(i + 50));
        do_reset();
        idle(1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'd1);
        idle(6);

        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) == 0,
                     $urandom());
            end
        end
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
